activation_plan: RTL

ACTIVATION_PLAN -- requirements
Module: activation_plan

---
 rtl/activation_plan.sv | 114 +++++++++++
 1 files changed

// File: rtl/activation_plan.sv
// Piecewise-linear (PLAN) sigmoid/tanh in signed Q(N-FRAC).FRAC.
// The three pipeline stages all advance together on one valid/ready handshake.
module activation_plan #(
  parameter int N    = 32,
  parameter int FRAC = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_data,
  input  logic         in_mode,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_data
);

  if (FRAC < 5 || N - FRAC < 4) begin : g_bad_params
    $error("activation_plan: need FRAC >= 5 and N-FRAC >= 4");
  end

  localparam logic [N-1:0] MAXP  = {1'b0, {(N-1){1'b1}}};
  localparam logic [N-1:0] MINN  = {1'b1, {(N-1){1'b0}}};
  localparam logic [N-1:0] ONE   = N'(1) << FRAC;
  localparam logic [N-1:0] K5    = N'(5) << FRAC;
  localparam logic [N-1:0] K2375 = N'(19) << (FRAC - 3);
  localparam logic [N-1:0] C84   = N'(27) << (FRAC - 5);
  localparam logic [N-1:0] C625  = N'(5) << (FRAC - 3);
  localparam logic [N-1:0] CHALF = N'(1) << (FRAC - 1);

  logic adv;

  logic         s1_v;
  logic         s1_sign;
  logic         s1_mode;
  logic [N-1:0] s1_mag;

  logic         s2_v;
  logic         s2_sign;
  logic         s2_mode;
  logic [N-1:0] s2_y;

  logic         ovf;
  logic [N-1:0] arg;
  logic [N-1:0] mag;
  logic         ge5;
  logic         ge2;
  logic         ge1;
  logic [N-1:0] y;
  logic [N-1:0] ys;
  logic [N-1:0] res;

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  // tanh evaluates the sigmoid at a saturated 2x
  always_comb begin
    ovf = in_data[N-1] ^ in_data[N-2];
    arg = in_data;
    if (in_mode) begin
      if (ovf) arg = in_data[N-1] ? MINN : MAXP;
      else     arg = {in_data[N-2:0], 1'b0};
    end
    if (arg == MINN)   mag = MAXP;
    else if (arg[N-1]) mag = -arg;
    else               mag = arg;
  end

  always_comb begin
    ge5 = s1_mag >= K5;
    ge2 = s1_mag >= K2375;
    ge1 = s1_mag >= ONE;
    y   = '0;
    unique case (1'b1)
      ge5:         y = ONE;
      ge2 && !ge5: y = (s1_mag >> 5) + C84;
      ge1 && !ge2: y = (s1_mag >> 3) + C625;
      !ge1:        y = (s1_mag >> 2) + CHALF;
      default:     y = '0;
    endcase
  end

  always_comb begin
    ys  = s2_sign ? ONE - s2_y : s2_y;
    res = s2_mode ? (ys << 1) - ONE : ys;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v      <= 1'b0;
      s1_sign   <= 1'b0;
      s1_mode   <= 1'b0;
      s1_mag    <= '0;
      s2_v      <= 1'b0;
      s2_sign   <= 1'b0;
      s2_mode   <= 1'b0;
      s2_y      <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (adv) begin
      s1_v      <= in_valid;
      s1_sign   <= arg[N-1];
      s1_mode   <= in_mode;
      s1_mag    <= mag;
      s2_v      <= s1_v;
      s2_sign   <= s1_sign;
      s2_mode   <= s1_mode;
      s2_y      <= y;
      out_valid <= s2_v;
      out_data  <= res;
    end
  end

endmodule
